// File: rtl/dma_priority_resolver_pkg.sv
// Shared types for the DMA priority resolver.
// Holds the state and mode enums and the default channel count.
package dmaPkg;

   localparam int NUM_CH_DEF = 4;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      GRANT,
      ACTIVE,
      RELEASE
   } state_e;

   typedef enum logic {
      SINGLE = 1'b0,
      DEMAND = 1'b1
   } mode_e;

endpackage

// File: rtl/dma_rr_pick.sv
// Rotate-and-find-first channel picker.
// Also intended for reuse by the cascade logic.
module dma_rr_pick
   import dmaPkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int CH_W   = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] pending_i,
   input  logic [CH_W-1:0]   ptr_i,
   input  logic              rotate_i,
   output logic [CH_W-1:0]   winner_o,
   output logic              any_o
);

   int idx;

   always_comb begin
      winner_o = '0;
      any_o    = 1'b0;
      idx      = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         // Rotating search begins just after the lowest-priority pointer.
         idx = rotate_i ? (int'(ptr_i) + 1 + i) % NUM_CH : i;
         if (!any_o && pending_i[idx]) begin
            any_o    = 1'b1;
            winner_o = CH_W'(idx);
         end
      end
   end

endmodule

// File: rtl/dma_priority_resolver.sv
// DMA channel arbiter and HRQ/HLDA bus-hold handshake engine.
// Grants one channel per hold and sequences its DACK with the timing strobes.
module dma_priority_resolver
   import dmaPkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int CH_W   = $clog2(NUM_CH)
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic [NUM_CH-1:0] dreq,
   input  logic [NUM_CH-1:0] swReq,
   input  logic [NUM_CH-1:0] maskReg,
   input  logic [NUM_CH-1:0] chMode,
   input  logic              rotatingPriority,
   input  logic              ctrlDisable,
   input  logic              hlda,
   input  logic              assertDACK,
   input  logic              deassertDACK,
   input  logic              intEOP,
   output logic              hrq,
   output logic [NUM_CH-1:0] dack,
   output logic [CH_W-1:0]   activeCh,
   output logic              chValid,
   output logic [NUM_CH-1:0] swReqClr
);

   state_e            state_q, state_d;
   logic              hrq_q, hrq_d;
   logic [NUM_CH-1:0] dack_q, dack_d;
   logic [CH_W-1:0]   activeCh_q, activeCh_d;
   logic              chValid_q, chValid_d;
   logic [NUM_CH-1:0] swReqClr_q, swReqClr_d;
   logic [CH_W-1:0]   ptr_q, ptr_d;
   logic              eop_q, eop_d;

   logic [NUM_CH-1:0] pending;
   logic [CH_W-1:0]   winner;
   logic              anyPend;
   logic              demandMore;

   assign pending = (dreq & ~maskReg) | swReq;

   dma_rr_pick #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_pick (
      .pending_i (pending),
      .ptr_i     (ptr_q),
      .rotate_i  (rotatingPriority),
      .winner_o  (winner),
      .any_o     (anyPend)
   );

   assign demandMore = (mode_e'(chMode[activeCh_q]) == DEMAND)
                     && pending[activeCh_q];

   always_comb begin
      state_d    = state_q;
      hrq_d      = hrq_q;
      dack_d     = dack_q;
      activeCh_d = activeCh_q;
      chValid_d  = chValid_q;
      swReqClr_d = '0;
      ptr_d      = ptr_q;
      eop_d      = eop_q;
      unique case (state_q)
         IDLE: begin
            eop_d = 1'b0;
            // A bit being cleared this cycle is already serviced.
            if (|(pending & ~swReqClr_q) && !ctrlDisable) begin
               hrq_d   = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            if (hlda) begin
               if (anyPend) begin
                  activeCh_d = winner;
                  chValid_d  = 1'b1;
                  state_d    = GRANT;
               end else begin
                  hrq_d   = 1'b0;
                  state_d = IDLE;
               end
            end
         end
         GRANT, ACTIVE: begin
            if (!hlda) begin
               hrq_d     = 1'b0;
               dack_d    = '0;
               chValid_d = 1'b0;
               eop_d     = 1'b0;
               state_d   = IDLE;
            end else begin
               if (intEOP) eop_d = 1'b1;
               if (deassertDACK && (state_q == ACTIVE || assertDACK)) begin
                  dack_d  = '0;
                  state_d = (eop_q || intEOP || !demandMore) ? RELEASE : GRANT;
               end else if (state_q == GRANT && assertDACK) begin
                  dack_d  = NUM_CH'(1) << activeCh_q;
                  state_d = ACTIVE;
               end
            end
         end
         RELEASE: begin
            hrq_d                  = 1'b0;
            chValid_d              = 1'b0;
            eop_d                  = 1'b0;
            swReqClr_d[activeCh_q] = swReq[activeCh_q];
            if (rotatingPriority) ptr_d = activeCh_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_q    <= IDLE;
         hrq_q      <= 1'b0;
         dack_q     <= '0;
         activeCh_q <= '0;
         chValid_q  <= 1'b0;
         swReqClr_q <= '0;
         ptr_q      <= CH_W'(NUM_CH - 1);
         eop_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         hrq_q      <= hrq_d;
         dack_q     <= dack_d;
         activeCh_q <= activeCh_d;
         chValid_q  <= chValid_d;
         swReqClr_q <= swReqClr_d;
         ptr_q      <= ptr_d;
         eop_q      <= eop_d;
      end
   end

   assign hrq      = hrq_q;
   assign dack     = dack_q;
   assign activeCh = activeCh_q;
   assign chValid  = chValid_q;
   assign swReqClr = swReqClr_q;

endmodule

// File: tb/tb_dma_priority_resolver.sv
// Directed bench for dma_priority_resolver (NUM_CH=4).
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_dma_priority_resolver;

   logic       clk = 1'b0;
   logic       resetN;
   logic [3:0] dreq, swReq, maskReg, chMode;
   logic       rotatingPriority, ctrlDisable, hlda;
   logic       assertDACK, deassertDACK, intEOP;
   logic       hrq, chValid;
   logic [3:0] dack, swReqClr;
   logic [1:0] activeCh;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dma_priority_resolver #(.NUM_CH(4)) dut (
      .clk              (clk),
      .resetN           (resetN),
      .dreq             (dreq),
      .swReq            (swReq),
      .maskReg          (maskReg),
      .chMode           (chMode),
      .rotatingPriority (rotatingPriority),
      .ctrlDisable      (ctrlDisable),
      .hlda             (hlda),
      .assertDACK       (assertDACK),
      .deassertDACK     (deassertDACK),
      .intEOP           (intEOP),
      .hrq              (hrq),
      .dack             (dack),
      .activeCh         (activeCh),
      .chValid          (chValid),
      .swReqClr         (swReqClr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One single-mode service from IDLE with requests already pending.
   task automatic serve(input logic [1:0] ch, input string tag);
      tick();
      chk({tag, "_hrq"}, 16'(hrq), 16'd1);
      hlda = 1'b1;
      tick();
      chk({tag, "_ch"}, 16'(activeCh), 16'(ch));
      chk({tag, "_vld"}, 16'(chValid), 16'd1);
      assertDACK = 1'b1;
      tick();
      assertDACK = 1'b0;
      chk({tag, "_dack"}, 16'(dack), 16'(4'b0001 << ch));
      deassertDACK = 1'b1;
      tick();
      deassertDACK = 1'b0;
      chk({tag, "_dack0"}, 16'(dack), 16'd0);
      tick();
      chk({tag, "_rel"}, 16'(hrq), 16'd0);
      hlda = 1'b0;
   endtask

   initial begin
      resetN = 1'b0; dreq = '0; swReq = '0; maskReg = '0; chMode = '0;
      rotatingPriority = 1'b0; ctrlDisable = 1'b0; hlda = 1'b0;
      assertDACK = 1'b0; deassertDACK = 1'b0; intEOP = 1'b0;
      tick(); tick();
      chk("rst_hrq", 16'(hrq), 16'd0);
      chk("rst_dack", 16'(dack), 16'd0);
      chk("rst_ch", 16'(activeCh), 16'd0);
      chk("rst_vld", 16'(chValid), 16'd0);
      chk("rst_clr", 16'(swReqClr), 16'd0);

      // Fixed priority, dreq=1010, hlda two cycles after hrq
      resetN = 1'b1;
      dreq   = 4'b1010;
      tick();
      chk("fix_hrq", 16'(hrq), 16'd1);
      tick();
      chk("fix_wait_vld", 16'(chValid), 16'd0);
      hlda = 1'b1;
      tick();
      chk("fix_ch", 16'(activeCh), 16'd1);
      chk("fix_vld", 16'(chValid), 16'd1);
      chk("fix_nodack", 16'(dack), 16'd0);
      assertDACK = 1'b1;
      tick();
      assertDACK = 1'b0;
      chk("fix_dack", 16'(dack), 16'b0010);
      deassertDACK = 1'b1;
      tick();
      deassertDACK = 1'b0;
      chk("fix_dack0", 16'(dack), 16'd0);
      chk("fix_hrq_rel", 16'(hrq), 16'd1);
      dreq = '0;
      tick();
      chk("fix_hrq0", 16'(hrq), 16'd0);
      chk("fix_vld0", 16'(chValid), 16'd0);
      hlda = 1'b0;
      tick();
      chk("fix_idle", 16'(hrq), 16'd0);

      // Rotating priority with all requests held
      rotatingPriority = 1'b1;
      dreq = 4'b1111;
      serve(2'd0, "rot0");
      serve(2'd1, "rot1");
      serve(2'd2, "rot2");
      serve(2'd3, "rot3");
      serve(2'd0, "rotwrap");
      dreq = '0;
      tick();

      // Demand burst on ch2, three transfers
      rotatingPriority = 1'b0;
      chMode = 4'b0100;
      dreq   = 4'b0100;
      tick();
      chk("dem_hrq", 16'(hrq), 16'd1);
      hlda = 1'b1;
      tick();
      chk("dem_ch", 16'(activeCh), 16'd2);
      for (int k = 0; k < 3; k++) begin
         assertDACK = 1'b1;
         tick();
         assertDACK = 1'b0;
         chk("dem_dack", 16'(dack), 16'b0100);
         if (k == 2) dreq = '0;
         deassertDACK = 1'b1;
         tick();
         deassertDACK = 1'b0;
         chk("dem_dack0", 16'(dack), 16'd0);
         chk("dem_hrq_hold", 16'(hrq), 16'd1);
      end
      tick();
      chk("dem_rel_hrq", 16'(hrq), 16'd0);
      chk("dem_rel_vld", 16'(chValid), 16'd0);
      hlda = 1'b0;
      chMode = '0;

      // Abort by hlda falling in ACTIVE; pointer must stay at ch0
      rotatingPriority = 1'b1;
      dreq = 4'b0110;
      tick();
      hlda = 1'b1;
      tick();
      chk("abt_ch", 16'(activeCh), 16'd1);
      assertDACK = 1'b1;
      tick();
      assertDACK = 1'b0;
      chk("abt_dack", 16'(dack), 16'b0010);
      hlda = 1'b0;
      tick();
      chk("abt_dack0", 16'(dack), 16'd0);
      chk("abt_hrq", 16'(hrq), 16'd0);
      chk("abt_vld", 16'(chValid), 16'd0);
      chk("abt_clr", 16'(swReqClr), 16'd0);
      serve(2'd1, "abt_ptr");
      dreq = '0;
      tick();

      // Request withdrawn before hlda
      rotatingPriority = 1'b0;
      dreq = 4'b0001;
      tick();
      chk("wd_hrq", 16'(hrq), 16'd1);
      dreq = '0;
      tick();
      hlda = 1'b1;
      tick();
      chk("wd_hrq0", 16'(hrq), 16'd0);
      chk("wd_vld", 16'(chValid), 16'd0);
      hlda = 1'b0;
      tick();
      chk("wd_idle", 16'(hrq), 16'd0);

      // Masked dreq ignored; swReq on masked ch3 is honoured
      maskReg = 4'b1000;
      dreq    = 4'b1000;
      tick();
      chk("msk_ign", 16'(hrq), 16'd0);
      swReq = 4'b1000;
      tick();
      chk("sw_hrq", 16'(hrq), 16'd1);
      hlda = 1'b1;
      tick();
      chk("sw_ch", 16'(activeCh), 16'd3);
      assertDACK = 1'b1;
      tick();
      assertDACK = 1'b0;
      chk("sw_dack", 16'(dack), 16'b1000);
      deassertDACK = 1'b1;
      tick();
      deassertDACK = 1'b0;
      chk("sw_clr_early", 16'(swReqClr), 16'd0);
      tick();
      chk("sw_clr", 16'(swReqClr), 16'b1000);
      chk("sw_hrq0", 16'(hrq), 16'd0);
      swReq = '0;
      hlda  = 1'b0;
      tick();
      chk("sw_clr_pulse", 16'(swReqClr), 16'd0);
      chk("sw_idle", 16'(hrq), 16'd0);
      dreq = '0;
      maskReg = '0;

      // assertDACK and deassertDACK together complete the transfer
      dreq = 4'b0001;
      tick();
      hlda = 1'b1;
      tick();
      assertDACK = 1'b1;
      deassertDACK = 1'b1;
      tick();
      assertDACK = 1'b0;
      deassertDACK = 1'b0;
      chk("both_dack", 16'(dack), 16'd0);
      dreq = '0;
      tick();
      chk("both_hrq0", 16'(hrq), 16'd0);
      hlda = 1'b0;

      // intEOP with deassertDACK ends a demand burst
      chMode = 4'b0001;
      dreq   = 4'b0001;
      tick();
      hlda = 1'b1;
      tick();
      assertDACK = 1'b1;
      tick();
      assertDACK = 1'b0;
      deassertDACK = 1'b1;
      intEOP = 1'b1;
      tick();
      deassertDACK = 1'b0;
      intEOP = 1'b0;
      dreq = '0;
      chk("eop_hrq_rel", 16'(hrq), 16'd1);
      tick();
      chk("eop_hrq0", 16'(hrq), 16'd0);
      hlda = 1'b0;
      chMode = '0;

      // ctrlDisable blocks a new hold request
      ctrlDisable = 1'b1;
      dreq = 4'b0010;
      tick();
      tick();
      chk("dis_hrq", 16'(hrq), 16'd0);
      ctrlDisable = 1'b0;
      dreq = '0;
      tick();

      // Reset mid-service returns outputs and pointer to reset values
      rotatingPriority = 1'b1;
      dreq = 4'b1111;
      tick();
      hlda = 1'b1;
      tick();
      chk("mr_ch", 16'(activeCh), 16'd2);
      assertDACK = 1'b1;
      tick();
      assertDACK = 1'b0;
      resetN = 1'b0;
      tick();
      chk("mr_hrq", 16'(hrq), 16'd0);
      chk("mr_dack", 16'(dack), 16'd0);
      chk("mr_ch0", 16'(activeCh), 16'd0);
      chk("mr_vld", 16'(chValid), 16'd0);
      resetN = 1'b1;
      hlda = 1'b0;
      serve(2'd0, "mr_ptr");
      dreq = '0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dma_priority_resolver.md
# dma_priority_resolver

N-channel request arbiter and bus-hold handshake engine for the DMA controller. Samples per-channel DREQ and software requests, negotiates the bus with the CPU over HRQ/HLDA, selects one channel under fixed or rotating priority, and drives that channel's DACK in step with the timing-control strobes assertDACK/deassertDACK. It is the parametrised successor of the 4-channel priority logic, adding configurable channel count, per-channel single/demand service, and abort handling.

## Interface
Parameters:
- NUM_CH, 4, number of DMA channels (2..16)
- CH_W, $clog2(NUM_CH), channel index width (derived, not overridden)

Ports:
- clk  in  1  controller clock
- resetN  in  1  reset; one clock; reset is synchronous and active-low
- dreq  in  NUM_CH  hardware requests, active-high, level-sensitive
- swReq  in  NUM_CH  software request bits from the request register
- maskReg  in  NUM_CH  1 = channel masked (ignores dreq; swReq still honoured)
- chMode  in  NUM_CH  0 = single transfer, 1 = demand
- rotatingPriority  in  1  command bit: 0 fixed (ch0 highest), 1 rotating
- ctrlDisable  in  1  command bit: 1 blocks new HRQ
- hlda  in  1  hold acknowledge from CPU
- assertDACK  in  1  timing-control pulse: start of transfer cycle
- deassertDACK  in  1  timing-control pulse: end of transfer cycle
- intEOP  in  1  internal end-of-process (terminal count or external EOP)
- hrq  out  1  hold request to CPU
- dack  out  NUM_CH  one-hot acknowledge, active-high
- activeCh  out  CH_W  index of granted channel
- chValid  out  1  activeCh is meaningful
- swReqClr  out  NUM_CH  one-cycle pulse clearing the serviced swReq bit

## Operation
- pending[i] = (dreq[i] & ~maskReg[i]) | swReq[i].
- States: IDLE, REQ, GRANT, ACTIVE, RELEASE.
- IDLE: if |pending & ~ctrlDisable -> REQ, hrq=1 next cycle.
- REQ: wait for hlda. On hlda=1: if |pending, latch winner into activeCh, chValid=1 -> GRANT; else hrq=0 -> IDLE.
- GRANT: on assertDACK, dack[activeCh]=1 -> ACTIVE.
- ACTIVE: on deassertDACK, dack=0. Then: intEOP seen during the service, or single mode, or (demand mode and pending[activeCh]=0) -> RELEASE; otherwise stay in GRANT for next cycle (demand burst).
- RELEASE: hrq=0, chValid=0, swReqClr[activeCh] pulse if swReq[activeCh]; if rotatingPriority, lowest-priority pointer := activeCh; -> IDLE.
- Fixed priority: lowest index wins. Rotating: search starts at pointer+1 mod NUM_CH, wraps.
- Winner is chosen only at the hlda-sample cycle; later higher-priority requests do not pre-empt.
- hlda falling while in GRANT/ACTIVE: abort — dack=0, hrq=0, chValid=0, no rotation, no swReqClr, -> IDLE next cycle.
- ctrlDisable asserted mid-service does not abort; it only blocks the next IDLE->REQ.
- maskReg set on active channel mid-burst: demand mode ends after the current transfer (pending drops).

## Timing
- Reset values: hrq=0, dack=0, activeCh=0, chValid=0, swReqClr=0, pointer=NUM_CH-1 (ch0 first), state IDLE.
- All outputs registered. pending->hrq: 1 cycle. hlda->chValid: 1 cycle. assertDACK->dack: 1 cycle. deassertDACK->dack low: 1 cycle; RELEASE->hrq low on the following cycle.
- assertDACK and deassertDACK in the same cycle: deassertDACK wins (dack stays 0, treated as completed transfer).
- intEOP coincident with deassertDACK counts for that transfer.
- resetN low in any state: all outputs return to reset values on the next edge, pointer reset.

## Structure
- Package dmaPkg: state enum (IDLE, REQ, GRANT, ACTIVE, RELEASE), mode enum (SINGLE, DEMAND), default NUM_CH constant.
- Sub-module dma_rr_pick: combinational rotate-and-find-first (pending, pointer, rotate enable -> winner index, any). Reused later by cascade logic.

## Test plan
- Fixed priority, dreq=4'b1010, hlda 2 cycles after hrq -> activeCh=1, dack=4'b0010 one cycle after assertDACK.
- Rotating, dreq=4'b1111 held, single mode, 4 services -> grant order 0,1,2,3, then 0 again (wrap).
- Demand mode ch2, dreq[2] held for 3 transfers then dropped -> hrq stays high for 3 deassertDACK pulses, RELEASE after 3rd.
- hlda dropped in ACTIVE -> dack=0, hrq=0 next cycle, pointer unchanged, swReqClr=0.
- dreq pulse withdrawn before hlda -> on hlda, no grant, hrq=0, state IDLE.
- swReq[3] with maskReg[3]=1 -> ch3 granted, swReqClr=4'b1000 one-cycle pulse in RELEASE.
